// File: rtl/fetch_redirect_ctrl_pkg.sv
// fetch_redirect_ctrl_pkg: shared types and defaults for the fetch redirect scheduler.
// The redirect source encoding doubles as the arbitration rank: a lower code wins.
package fetch_redirect_ctrl_pkg;

    localparam int unsigned DEF_EPOCH_W  = 3;
    localparam logic [31:0] DEF_START_PC = 32'h1c00_0000;

    typedef enum logic [2:0] {
        SRC_RESET  = 3'd0,
        SRC_BRANCH = 3'd1,
        SRC_EXCP   = 3'd2,
        SRC_ERTN   = 3'd3,
        SRC_IDLE   = 3'd4,
        SRC_JUMP   = 3'd5,
        SRC_MISS   = 3'd6,
        SRC_PRED   = 3'd7
    } redir_src_e;

    typedef enum logic [1:0] {
        FSM_RUN     = 2'd0,
        FSM_IDLE    = 2'd1,
        FSM_RECOVER = 2'd2
    } fsm_e;

    // True when source a outranks source b
    function automatic logic higherPrio(input redir_src_e a, input redir_src_e b);
        return a < b;
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_redir_prio_mux.sv
// redir_prio_mux: combinational fixed-priority select of the winning backend
// and frontend redirect requests. Callers gate the valids for state masking.
module redir_prio_mux
    import fetch_redirect_ctrl_pkg::*;
(
    input  logic        branch_vld_i,
    input  logic        rob_taken_i,
    input  logic [31:0] rob_target_i,
    input  logic [31:0] rob_pc_i,
    input  logic        excp_vld_i,
    input  logic [31:0] excp_target_i,
    input  logic        ertn_vld_i,
    input  logic [31:0] ertn_target_i,
    input  logic        idle_vld_i,
    input  logic        jump_vld_i,
    input  logic [31:0] jump_target_i,
    input  logic        miss_vld_i,
    input  logic [31:0] miss_pc_i,
    input  logic        pred_vld_i,
    input  logic [31:0] pred_target_i,
    output logic        be_vld_o,
    output redir_src_e  be_src_o,
    output logic [31:0] be_target_o,
    output logic        fe_vld_o,
    output redir_src_e  fe_src_o,
    output logic [31:0] fe_target_o
);

    logic [31:0] seqPc;
    assign seqPc = rob_pc_i + 32'd4;

    // Backend winner: branch > exception > ertn > idle
    always_comb begin
        be_vld_o    = 1'b0;
        be_src_o    = SRC_BRANCH;
        be_target_o = '0;
        if (branch_vld_i) begin
            be_vld_o    = 1'b1;
            be_src_o    = SRC_BRANCH;
            be_target_o = rob_taken_i ? rob_target_i : seqPc;
        end else if (excp_vld_i) begin
            be_vld_o    = 1'b1;
            be_src_o    = SRC_EXCP;
            be_target_o = excp_target_i;
        end else if (ertn_vld_i) begin
            be_vld_o    = 1'b1;
            be_src_o    = SRC_ERTN;
            be_target_o = ertn_target_i;
        end else if (idle_vld_i) begin
            be_vld_o    = 1'b1;
            be_src_o    = SRC_IDLE;
            be_target_o = seqPc;
        end
    end

    // Frontend winner: jump > miss > prediction
    always_comb begin
        fe_vld_o    = 1'b0;
        fe_src_o    = SRC_PRED;
        fe_target_o = '0;
        if (jump_vld_i) begin
            fe_vld_o    = 1'b1;
            fe_src_o    = SRC_JUMP;
            fe_target_o = jump_target_i;
        end else if (miss_vld_i) begin
            fe_vld_o    = 1'b1;
            fe_src_o    = SRC_MISS;
            fe_target_o = miss_pc_i;
        end else if (pred_vld_i) begin
            fe_vld_o    = 1'b1;
            fe_src_o    = SRC_PRED;
            fe_target_o = pred_target_i;
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: schedules all PC redirects, idle wait, post-flush
// recovery bubbles and the fetch epoch. Every output is registered.
// Optional per-source redirect counters are built when REDIRECT_PERF_EN is defined.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned EPOCH_W     = DEF_EPOCH_W,
    parameter int unsigned RECOVER_CYC = 2,
    parameter logic [31:0] START_PC    = DEF_START_PC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rob_branch_vld,
    input  logic               rob_taken,
    input  logic [31:0]        rob_target,
    input  logic [31:0]        rob_pc,
    input  logic               excp_vld,
    input  logic [31:0]        excp_target,
    input  logic               ertn_vld,
    input  logic [31:0]        ertn_target,
    input  logic               idle_vld,
    input  logic               intr_pending,
    input  logic               pd_jump_vld,
    input  logic [31:0]        pd_jump_target,
    input  logic               pd_miss_vld,
    input  logic [31:0]        pd_miss_pc,
    input  logic               bpu_pred_vld,
    input  logic [31:0]        bpu_target,
    input  logic               ififo_full,
    output logic               redir_vld,
    output logic [31:0]        redir_target,
    output logic [2:0]         redir_src,
    output logic               fetch_hold,
    output logic               flush_fe,
    output logic [EPOCH_W-1:0] epoch,
    output logic [1:0]         state_o
`ifdef REDIRECT_PERF_EN
    ,
    input  logic [2:0]         perf_sel,
    output logic [31:0]        perf_cnt
`endif
);

    localparam int unsigned CNT_W = (RECOVER_CYC > 2) ? $clog2(RECOVER_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = (RECOVER_CYC > 0) ? CNT_W'(RECOVER_CYC - 1) : '0;

    logic               resetIssue_q, resetIssue_d;
    logic               redirVld_q, redirVld_d;
    logic [31:0]        redirTarget_q, redirTarget_d;
    redir_src_e         redirSrc_q, redirSrc_d;
    logic               fetchHold_q, fetchHold_d;
    logic               flushFe_q, flushFe_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    fsm_e               state_q, state_d;
    logic [CNT_W-1:0]   recoverCnt_q, recoverCnt_d;
    logic               pendVld_q, pendVld_d;
    redir_src_e         pendSrc_q, pendSrc_d;
    logic [31:0]        pendTarget_q, pendTarget_d;

    logic               inRun, inIdle;
    logic               beVld, feVld;
    redir_src_e         beSrc, feSrc;
    logic [31:0]        beTarget, feTarget;

    assign inRun  = (state_q == FSM_RUN);
    assign inIdle = (state_q == FSM_IDLE);

    // Frontend requests only count in RUN; IDLE accepts only branch/exception
    redir_prio_mux u_prio (
        .branch_vld_i  (rob_branch_vld),
        .rob_taken_i   (rob_taken),
        .rob_target_i  (rob_target),
        .rob_pc_i      (rob_pc),
        .excp_vld_i    (excp_vld),
        .excp_target_i (excp_target),
        .ertn_vld_i    (ertn_vld & ~inIdle),
        .ertn_target_i (ertn_target),
        .idle_vld_i    (idle_vld & ~inIdle),
        .jump_vld_i    (pd_jump_vld & inRun),
        .jump_target_i (pd_jump_target),
        .miss_vld_i    (pd_miss_vld & inRun),
        .miss_pc_i     (pd_miss_pc),
        .pred_vld_i    (bpu_pred_vld & inRun),
        .pred_target_i (bpu_target),
        .be_vld_o      (beVld),
        .be_src_o      (beSrc),
        .be_target_o   (beTarget),
        .fe_vld_o      (feVld),
        .fe_src_o      (feSrc),
        .fe_target_o   (feTarget)
    );

    // Next-state: boot redirect, backend flushes, FSM sequencing and pend handling
    always_comb begin
        resetIssue_d  = 1'b0;
        redirVld_d    = 1'b0;
        redirTarget_d = redirTarget_q;
        redirSrc_d    = redirSrc_q;
        flushFe_d     = 1'b0;
        epoch_d       = epoch_q;
        state_d       = state_q;
        recoverCnt_d  = recoverCnt_q;
        pendVld_d     = pendVld_q;
        pendSrc_d     = pendSrc_q;
        pendTarget_d  = pendTarget_q;
        if (resetIssue_q) begin
            redirVld_d    = 1'b1;
            redirTarget_d = START_PC;
            redirSrc_d    = SRC_RESET;
        end else if (beVld) begin
            redirVld_d    = 1'b1;
            redirTarget_d = beTarget;
            redirSrc_d    = beSrc;
            flushFe_d     = 1'b1;
            epoch_d       = epoch_q + EPOCH_W'(1);
            pendVld_d     = 1'b0;
            if (beSrc == SRC_IDLE) begin
                state_d = FSM_IDLE;
            end else if (RECOVER_CYC > 0) begin
                state_d      = FSM_RECOVER;
                recoverCnt_d = CNT_RELOAD;
            end else begin
                state_d = FSM_RUN;
            end
        end else begin
            unique case (state_q)
                FSM_RECOVER: begin
                    if (recoverCnt_q == '0) state_d = FSM_RUN;
                    else                    recoverCnt_d = recoverCnt_q - CNT_W'(1);
                end
                FSM_IDLE: begin
                    if (intr_pending) state_d = FSM_RUN;
                end
                default: begin
                    if (ififo_full) begin
                        if (feVld && (!pendVld_q || higherPrio(feSrc, pendSrc_q))) begin
                            pendVld_d    = 1'b1;
                            pendSrc_d    = feSrc;
                            pendTarget_d = feTarget;
                        end
                    end else if (pendVld_q && !(feVld && higherPrio(feSrc, pendSrc_q))) begin
                        redirVld_d    = 1'b1;
                        redirTarget_d = pendTarget_q;
                        redirSrc_d    = pendSrc_q;
                        pendVld_d     = 1'b0;
                    end else if (feVld) begin
                        redirVld_d    = 1'b1;
                        redirTarget_d = feTarget;
                        redirSrc_d    = feSrc;
                        pendVld_d     = 1'b0;
                    end
                end
            endcase
        end
        fetchHold_d = ififo_full | (state_d != FSM_RUN);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            resetIssue_q  <= 1'b1;
            redirVld_q    <= 1'b0;
            redirTarget_q <= START_PC;
            redirSrc_q    <= SRC_RESET;
            fetchHold_q   <= 1'b1;
            flushFe_q     <= 1'b0;
            epoch_q       <= '0;
            state_q       <= FSM_RUN;
            recoverCnt_q  <= '0;
            pendVld_q     <= 1'b0;
            pendSrc_q     <= SRC_PRED;
            pendTarget_q  <= '0;
        end else begin
            resetIssue_q  <= resetIssue_d;
            redirVld_q    <= redirVld_d;
            redirTarget_q <= redirTarget_d;
            redirSrc_q    <= redirSrc_d;
            fetchHold_q   <= fetchHold_d;
            flushFe_q     <= flushFe_d;
            epoch_q       <= epoch_d;
            state_q       <= state_d;
            recoverCnt_q  <= recoverCnt_d;
            pendVld_q     <= pendVld_d;
            pendSrc_q     <= pendSrc_d;
            pendTarget_q  <= pendTarget_d;
        end
    end

    assign redir_vld    = redirVld_q;
    assign redir_target = redirTarget_q;
    assign redir_src    = redirSrc_q;
    assign fetch_hold   = fetchHold_q;
    assign flush_fe     = flushFe_q;
    assign epoch        = epoch_q;
    assign state_o      = state_q;

`ifdef REDIRECT_PERF_EN
    // Slot 0 counts idle cycles, slots 1-7 count issued redirects per source
    logic [31:0] perfCnt_q [0:7];

    // Saturating performance counters, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) perfCnt_q[i] <= '0;
        end else begin
            if (inIdle && perfCnt_q[0] != '1) perfCnt_q[0] <= perfCnt_q[0] + 32'd1;
            if (redirVld_d && redirSrc_d != SRC_RESET && perfCnt_q[redirSrc_d] != '1)
                perfCnt_q[redirSrc_d] <= perfCnt_q[redirSrc_d] + 32'd1;
        end
    end

    assign perf_cnt = perfCnt_q[perf_sel];
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: directed scenario tasks plus randomized traffic,
// all checked against a behavioural reference of the redirect rules.
module tb_fetch_redirect_ctrl;

    localparam int          RC    = 2;
    localparam logic [31:0] START = 32'h1c00_0000;

    logic        clk, rst;
    logic        rob_branch_vld, rob_taken, excp_vld, ertn_vld, idle_vld, intr_pending;
    logic [31:0] rob_target, rob_pc, excp_target, ertn_target;
    logic        pd_jump_vld, pd_miss_vld, bpu_pred_vld, ififo_full;
    logic [31:0] pd_jump_target, pd_miss_pc, bpu_target;
    logic        redir_vld, fetch_hold, flush_fe;
    logic [31:0] redir_target;
    logic [2:0]  redir_src;
    logic [2:0]  epoch;
    logic [1:0]  state_o;

    int errors = 0;
    int checks = 0;

    fetch_redirect_ctrl #(.EPOCH_W(3), .RECOVER_CYC(RC), .START_PC(START)) dut (
        .clk(clk), .rst(rst),
        .rob_branch_vld(rob_branch_vld), .rob_taken(rob_taken), .rob_target(rob_target), .rob_pc(rob_pc),
        .excp_vld(excp_vld), .excp_target(excp_target), .ertn_vld(ertn_vld), .ertn_target(ertn_target),
        .idle_vld(idle_vld), .intr_pending(intr_pending),
        .pd_jump_vld(pd_jump_vld), .pd_jump_target(pd_jump_target),
        .pd_miss_vld(pd_miss_vld), .pd_miss_pc(pd_miss_pc),
        .bpu_pred_vld(bpu_pred_vld), .bpu_target(bpu_target), .ififo_full(ififo_full),
        .redir_vld(redir_vld), .redir_target(redir_target), .redir_src(redir_src),
        .fetch_hold(fetch_hold), .flush_fe(flush_fe), .epoch(epoch), .state_o(state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: mode 0 run, 1 idle, 2 recover; rank = source code
    bit          mBoot = 1'b1;
    int          mMode = 0;
    int          mRecLeft = 0;
    bit          mPend = 1'b0;
    int          mPendRank = 0;
    logic [31:0] mPendTgt = '0;
    bit          mV [1:7];
    logic [31:0] mT [1:7];
    bit          eVld = 1'b0, eFlush = 1'b0, eHold = 1'b1;
    int          eEpoch = 0, eState = 0, eSrc = 0;
    logic [31:0] eTgt = '0;

    always @(posedge clk) begin : refModel
        int be;
        int fe;
        mV[1] = rob_branch_vld; mT[1] = rob_taken ? rob_target : rob_pc + 32'd4;
        mV[2] = excp_vld;       mT[2] = excp_target;
        mV[3] = ertn_vld;       mT[3] = ertn_target;
        mV[4] = idle_vld;       mT[4] = rob_pc + 32'd4;
        mV[5] = pd_jump_vld;    mT[5] = pd_jump_target;
        mV[6] = pd_miss_vld;    mT[6] = pd_miss_pc;
        mV[7] = bpu_pred_vld;   mT[7] = bpu_target;
        eVld = 1'b0;
        eFlush = 1'b0;
        if (rst) begin
            mBoot = 1'b1; mMode = 0; mPend = 1'b0; eEpoch = 0;
        end else if (mBoot) begin
            mBoot = 1'b0; eVld = 1'b1; eTgt = START; eSrc = 0;
        end else begin
            be = 0;
            for (int r = 4; r >= 1; r--) if (mV[r] && (mMode != 1 || r <= 2)) be = r;
            fe = 0;
            if (mMode == 0) for (int r = 7; r >= 5; r--) if (mV[r]) fe = r;
            if (be != 0) begin
                eVld = 1'b1; eTgt = mT[be]; eSrc = be; eFlush = 1'b1;
                eEpoch = (eEpoch + 1) % 8;
                mPend = 1'b0;
                if (be == 4) mMode = 1;
                else if (RC > 0) begin mMode = 2; mRecLeft = RC; end
                else mMode = 0;
            end else if (mMode == 2) begin
                mRecLeft--;
                if (mRecLeft == 0) mMode = 0;
            end else if (mMode == 1) begin
                if (intr_pending) mMode = 0;
            end else if (ififo_full) begin
                if (fe != 0 && (!mPend || fe < mPendRank)) begin
                    mPend = 1'b1; mPendRank = fe; mPendTgt = mT[fe];
                end
            end else if (mPend && !(fe != 0 && fe < mPendRank)) begin
                eVld = 1'b1; eTgt = mPendTgt; eSrc = mPendRank; mPend = 1'b0;
            end else if (fe != 0) begin
                eVld = 1'b1; eTgt = mT[fe]; eSrc = fe; mPend = 1'b0;
            end
        end
        eHold = rst || ififo_full || mMode != 0;
        eState = mMode;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        rob_branch_vld = 0; rob_taken = 0; rob_target = '0; rob_pc = '0;
        excp_vld = 0; excp_target = '0; ertn_vld = 0; ertn_target = '0;
        idle_vld = 0; intr_pending = 0;
        pd_jump_vld = 0; pd_jump_target = '0; pd_miss_vld = 0; pd_miss_pc = '0;
        bpu_pred_vld = 0; bpu_target = '0; ififo_full = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        clearInputs();
        repeat (3) tick();
        checks++;
        if ({redir_vld, fetch_hold, flush_fe, epoch, state_o} !== {1'b0, 1'b1, 1'b0, 3'd0, 2'd0}) begin
            errors++;
            $display("[TB] FAIL reset_hold: vld=%0b hold=%0b flush=%0b epoch=%0d state=%0d want 0 1 0 0 0",
                     redir_vld, fetch_hold, flush_fe, epoch, state_o);
        end
        rst = 0;
        tick();
        checks++;
        if ({redir_vld, redir_target, redir_src, epoch} !== {1'b1, START, 3'd0, 3'd0}) begin
            errors++;
            $display("[TB] FAIL reset_boot: vld=%0b tgt=%h src=%0d epoch=%0d want 1 %h 0 0",
                     redir_vld, redir_target, redir_src, epoch, START);
        end
        tick();
    endtask

    task automatic test_branch_vs_pred();
        rob_branch_vld = 1; rob_taken = 0; rob_pc = 32'h1c00_0100; rob_target = 32'h1c00_9990;
        bpu_pred_vld = 1; bpu_target = 32'h1c00_7770;
        tick();
        clearInputs();
        checks++;
        if ({redir_vld, redir_target, redir_src, flush_fe, epoch, fetch_hold, state_o}
            !== {1'b1, 32'h1c00_0104, 3'd1, 1'b1, 3'd1, 1'b1, 2'd2}) begin
            errors++;
            $display("[TB] FAIL branch_issue: vld=%0b tgt=%h src=%0d flush=%0b epoch=%0d hold=%0b state=%0d want 1 1c000104 1 1 1 1 2",
                     redir_vld, redir_target, redir_src, flush_fe, epoch, fetch_hold, state_o);
        end
        tick();
        checks++;
        if ({redir_vld, flush_fe, fetch_hold, state_o} !== {1'b0, 1'b0, 1'b1, 2'd2}) begin
            errors++;
            $display("[TB] FAIL branch_recover2: vld=%0b flush=%0b hold=%0b state=%0d want 0 0 1 2",
                     redir_vld, flush_fe, fetch_hold, state_o);
        end
        tick();
        checks++;
        if ({fetch_hold, state_o} !== {1'b0, 2'd0}) begin
            errors++;
            $display("[TB] FAIL branch_release: hold=%0b state=%0d want 0 0", fetch_hold, state_o);
        end
    endtask

    task automatic test_pending_jump();
        ififo_full = 1; pd_jump_vld = 1; pd_jump_target = 32'h1c00_0200;
        tick();
        pd_jump_vld = 0;
        for (int i = 0; i < 3; i++) begin
            bpu_pred_vld = (i == 1); bpu_target = 32'h1c00_5550;
            tick();
            checks++;
            if ({redir_vld, fetch_hold} !== {1'b0, 1'b1}) begin
                errors++;
                $display("[TB] FAIL pend_wait%0d: vld=%0b hold=%0b want 0 1", i, redir_vld, fetch_hold);
            end
        end
        bpu_pred_vld = 0; ififo_full = 0;
        tick();
        checks++;
        if ({redir_vld, redir_target, redir_src, flush_fe, epoch} !== {1'b1, 32'h1c00_0200, 3'd5, 1'b0, 3'd1}) begin
            errors++;
            $display("[TB] FAIL pend_issue: vld=%0b tgt=%h src=%0d flush=%0b epoch=%0d want 1 1c000200 5 0 1",
                     redir_vld, redir_target, redir_src, flush_fe, epoch);
        end
        tick();
        checks++;
        if (redir_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pend_once: vld=%0b want 0", redir_vld);
        end
    endtask

    task automatic test_idle_wake();
        idle_vld = 1; rob_pc = 32'h1c00_0300;
        tick();
        clearInputs();
        checks++;
        if ({redir_vld, redir_target, redir_src, state_o, fetch_hold, epoch} !== {1'b1, 32'h1c00_0304, 3'd4, 2'd1, 1'b1, 3'd2}) begin
            errors++;
            $display("[TB] FAIL idle_issue: vld=%0b tgt=%h src=%0d state=%0d hold=%0b epoch=%0d want 1 1c000304 4 1 1 2",
                     redir_vld, redir_target, redir_src, state_o, fetch_hold, epoch);
        end
        bpu_pred_vld = 1; bpu_target = 32'h1c00_1230;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({redir_vld, fetch_hold, state_o} !== {1'b0, 1'b1, 2'd1}) begin
                errors++;
                $display("[TB] FAIL idle_wait%0d: vld=%0b hold=%0b state=%0d want 0 1 1", i, redir_vld, fetch_hold, state_o);
            end
        end
        bpu_pred_vld = 0; intr_pending = 1;
        tick();
        intr_pending = 0;
        checks++;
        if ({redir_vld, state_o, fetch_hold} !== {1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL idle_wake: vld=%0b state=%0d hold=%0b want 0 0 0", redir_vld, state_o, fetch_hold);
        end
        excp_vld = 1; excp_target = 32'h1c00_8000;
        tick();
        clearInputs();
        checks++;
        if ({redir_vld, redir_target, redir_src, epoch, state_o} !== {1'b1, 32'h1c00_8000, 3'd2, 3'd3, 2'd2}) begin
            errors++;
            $display("[TB] FAIL excp_issue: vld=%0b tgt=%h src=%0d epoch=%0d state=%0d want 1 1c008000 2 3 2",
                     redir_vld, redir_target, redir_src, epoch, state_o);
        end
        repeat (2) tick();
    endtask

    task automatic test_epoch_wrap_ertn();
        for (int i = 0; i < 8; i++) begin
            ertn_vld = 1; ertn_target = 32'h1c00_0400;
            tick();
            checks++;
            if ({redir_vld, redir_target, redir_src, epoch} !== {1'b1, 32'h1c00_0400, 3'd3, 3'((3 + i + 1) % 8)}) begin
                errors++;
                $display("[TB] FAIL ertn%0d: vld=%0b tgt=%h src=%0d epoch=%0d want 1 1c000400 3 %0d",
                         i, redir_vld, redir_target, redir_src, epoch, (3 + i + 1) % 8);
            end
        end
        clearInputs();
        pd_jump_vld = 1; pd_jump_target = 32'h1c00_0ab0;
        tick();
        pd_jump_vld = 0;
        checks++;
        if ({redir_vld, state_o} !== {1'b0, 2'd2}) begin
            errors++;
            $display("[TB] FAIL jump_masked: vld=%0b state=%0d want 0 2", redir_vld, state_o);
        end
        tick();
        checks++;
        if ({redir_vld, state_o} !== {1'b0, 2'd0}) begin
            errors++;
            $display("[TB] FAIL recover_exit: vld=%0b state=%0d want 0 0", redir_vld, state_o);
        end
    endtask

    task automatic test_reset_mid();
        ififo_full = 1; pd_miss_vld = 1; pd_miss_pc = 32'h1c00_0600;
        tick();
        clearInputs();
        rst = 1;
        tick();
        checks++;
        if ({redir_vld, fetch_hold, state_o, epoch} !== {1'b0, 1'b1, 2'd0, 3'd0}) begin
            errors++;
            $display("[TB] FAIL rstmid_pend: vld=%0b hold=%0b state=%0d epoch=%0d want 0 1 0 0",
                     redir_vld, fetch_hold, state_o, epoch);
        end
        rst = 0;
        tick();
        tick();
        checks++;
        if (redir_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_pend_gone: vld=%0b want 0", redir_vld);
        end
        rob_branch_vld = 1; rob_taken = 1; rob_target = 32'h1c00_0700;
        tick();
        clearInputs();
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if ({state_o, epoch, fetch_hold, redir_vld} !== {2'd0, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL rstmid_recover: state=%0d epoch=%0d hold=%0b vld=%0b want 0 0 1 0",
                     state_o, epoch, fetch_hold, redir_vld);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst            = ($urandom_range(0, 199) == 0);
            rob_branch_vld = ($urandom_range(0, 19) == 0);
            rob_taken      = $urandom_range(0, 1);
            rob_target     = $urandom;
            rob_pc         = ($urandom_range(0, 7) == 0) ? 32'hffff_fffc : $urandom;
            excp_vld       = ($urandom_range(0, 29) == 0);
            excp_target    = $urandom;
            ertn_vld       = ($urandom_range(0, 29) == 0);
            ertn_target    = $urandom;
            idle_vld       = ($urandom_range(0, 39) == 0);
            intr_pending   = ($urandom_range(0, 7) == 0);
            pd_jump_vld    = ($urandom_range(0, 4) == 0);
            pd_jump_target = $urandom;
            pd_miss_vld    = ($urandom_range(0, 4) == 0);
            pd_miss_pc     = $urandom;
            bpu_pred_vld   = ($urandom_range(0, 2) == 0);
            bpu_target     = $urandom;
            ififo_full     = ($urandom_range(0, 2) == 0);
            tick();
            checks++;
            if ({redir_vld, flush_fe, fetch_hold, epoch, state_o} !== {eVld, eFlush, eHold, 3'(eEpoch), 2'(eState)}) begin
                errors++;
                $display("[TB] FAIL rand_ctrl@%0d: vld=%0b flush=%0b hold=%0b epoch=%0d state=%0d want %0b %0b %0b %0d %0d",
                         c, redir_vld, flush_fe, fetch_hold, epoch, state_o, eVld, eFlush, eHold, eEpoch, eState);
            end
            if (eVld) begin
                checks++;
                if ({redir_target, redir_src} !== {eTgt, 3'(eSrc)}) begin
                    errors++;
                    $display("[TB] FAIL rand_redir@%0d: tgt=%h src=%0d want %h %0d", c, redir_target, redir_src, eTgt, eSrc);
                end
            end
        end
        rst = 0;
        clearInputs();
    endtask

    initial begin
        rst = 1;
        clearInputs();
        test_reset();
        test_branch_vs_pred();
        test_pending_jump();
        test_idle_wake();
        test_epoch_wrap_ertn();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
